// File: rtl/kernel_onchip_memory2_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two pipelined
// Avalon-MM masters, with out-of-range detection and fixed one-cycle read return.
module kernel_onchip_memory2_arbiter #(
  parameter int                 ADDR_W    = 15,
  parameter int                 DATA_W    = 32,
  parameter int                 BE_W      = 4,
  parameter int                 MEM_DEPTH = 20230,
  parameter logic [DATA_W-1:0]  OOR_RDATA = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              oor_error,
  input  logic              oor_clear
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic              w_req0;
  logic              w_req1;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr;
  logic              w_oor;
  logic              w_rd_acc;

  logic r_last_grant;
  logic r_rd_pend0;
  logic r_rd_pend1;
  logic r_rd_oor;
  logic r_oor_error;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Round-robin grant; a tie goes to the master that was not served last.
  // Grants are held off while in reset so the RAM sees no access.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset_n) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else if (w_req0 && w_req1) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = w_req0;
      w_grant1 = w_req1;
    end
  end

  // Route the granted master's request onto the RAM port.
  always_comb begin
    w_addr  = m0_address;
    w_be    = m0_byteenable;
    w_wdata = m0_writedata;
    w_wr    = m0_write;
    if (w_grant1) begin
      w_addr  = m1_address;
      w_be    = m1_byteenable;
      w_wdata = m1_writedata;
      w_wr    = m1_write;
    end else begin
      w_addr  = m0_address;
      w_be    = m0_byteenable;
      w_wdata = m0_writedata;
      w_wr    = m0_write;
    end
  end

  assign w_any    = w_grant0 | w_grant1;
  assign w_oor    = ({1'b0, w_addr} >= DEPTH_L);
  assign w_rd_acc = w_any & ~w_wr;

  assign m0_waitrequest = w_req0 & ~w_grant0;
  assign m1_waitrequest = w_req1 & ~w_grant1;

  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = w_any;
  assign mem_write      = w_any & w_wr & ~w_oor;
  assign mem_clken      = 1'b1;

  // Both masters see the RAM data bus; only the valid strobe distinguishes the owner.
  assign m0_readdata      = r_rd_oor ? OOR_RDATA : mem_readdata;
  assign m1_readdata      = r_rd_oor ? OOR_RDATA : mem_readdata;
  assign m0_readdatavalid = r_rd_pend0;
  assign m1_readdatavalid = r_rd_pend1;
  assign oor_error        = r_oor_error;

  // Arbitration history, read-return tracking and sticky out-of-range flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_rd_pend0   <= 1'b0;
      r_rd_pend1   <= 1'b0;
      r_rd_oor     <= 1'b0;
      r_oor_error  <= 1'b0;
    end else begin
      if (w_any) begin
        r_last_grant <= w_grant1;
      end else begin
        r_last_grant <= r_last_grant;
      end
      r_rd_pend0 <= w_grant0 & ~m0_write;
      r_rd_pend1 <= w_grant1 & ~m1_write;
      r_rd_oor   <= w_rd_acc & w_oor;
      // A new out-of-range access outranks a clear in the same cycle.
      if (w_any && w_oor) begin
        r_oor_error <= 1'b1;
      end else if (oor_clear) begin
        r_oor_error <= 1'b0;
      end else begin
        r_oor_error <= r_oor_error;
      end
    end
  end

endmodule
